// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N-channel button synchroniser, tick-based debouncer and auto-repeat pulse generator
module btn_debounce_multi #(
   parameter int N = 2,
   parameter int TICK_CYCLES = 25000,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY_TICKS = 500,
   parameter int REPEAT_RATE_TICKS = 100,
   parameter bit ACTIVE_HIGH = 1'b1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] btn_in,
   input  logic [N-1:0] repeat_en,
   output logic [N-1:0] level,
   output logic [N-1:0] press,
   output logic [N-1:0] release_pulse,
   output logic [N-1:0] repeat_pulse
);
   localparam int MAX_A = DEBOUNCE_TICKS > REPEAT_DELAY_TICKS ? DEBOUNCE_TICKS : REPEAT_DELAY_TICKS;
   localparam int MAX_T = MAX_A > REPEAT_RATE_TICKS ? MAX_A : REPEAT_RATE_TICKS;
   localparam int CW = MAX_T > 1 ? $clog2(MAX_T) : 1;
   localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
   localparam logic [N-1:0] INACTIVE = {N{~ACTIVE_HIGH}};
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_TICKS - 1);
   localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY_TICKS - 1);
   localparam logic [CW-1:0] RR_LAST = CW'(REPEAT_RATE_TICKS - 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_REL} state_t;

   logic [N-1:0] sync0, sync1, s;
   logic [PW-1:0] pre;
   logic tick;

   // two-flop synchroniser, parked at the released level during reset
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync0 <= INACTIVE;
         sync1 <= INACTIVE;
      end else begin
         sync0 <= btn_in;
         sync1 <= sync0;
      end
   end

   assign s = sync1 ^ INACTIVE;
   assign tick = pre == PRE_LAST;

   // free-running shared timebase; tick marks the last count of each period
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) pre <= '0;
      else pre <= tick ? '0 : pre + 1'b1;
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      state_t st;
      logic [CW-1:0] cnt;
      logic lvl, prs, rel, rpt;

      // per-channel debounce/repeat FSM; an input change always wins over a tick
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            st <= IDLE;
            cnt <= '0;
            lvl <= 1'b0;
            prs <= 1'b0;
            rel <= 1'b0;
            rpt <= 1'b0;
         end else begin
            prs <= 1'b0;
            rel <= 1'b0;
            rpt <= 1'b0;
            case (st)
               IDLE: if (s[i]) begin
                  st <= DB_PRESS;
                  cnt <= '0;
               end
               DB_PRESS: if (!s[i]) st <= IDLE;
               else if (tick) begin
                  if (cnt == DB_LAST) begin
                     st <= HELD;
                     cnt <= '0;
                     lvl <= 1'b1;
                     prs <= 1'b1;
                  end else cnt <= cnt + 1'b1;
               end
               HELD: if (!s[i]) begin
                  st <= DB_REL;
                  cnt <= '0;
               end else if (!repeat_en[i]) cnt <= '0;
               else if (tick) begin
                  if (cnt == RD_LAST) begin
                     st <= REPEAT;
                     cnt <= '0;
                     prs <= 1'b1;
                     rpt <= 1'b1;
                  end else cnt <= cnt + 1'b1;
               end
               REPEAT: if (!s[i]) begin
                  st <= DB_REL;
                  cnt <= '0;
               end else if (!repeat_en[i]) begin
                  st <= HELD;
                  cnt <= '0;
               end else if (tick) begin
                  if (cnt == RR_LAST) begin
                     cnt <= '0;
                     prs <= 1'b1;
                     rpt <= 1'b1;
                  end else cnt <= cnt + 1'b1;
               end
               DB_REL: if (s[i]) begin
                  st <= HELD;
                  cnt <= '0;
               end else if (tick) begin
                  if (cnt == DB_LAST) begin
                     st <= IDLE;
                     lvl <= 1'b0;
                     rel <= 1'b1;
                  end else cnt <= cnt + 1'b1;
               end
               default: st <= IDLE;
            endcase
         end
      end

      assign level[i] = lvl;
      assign press[i] = prs;
      assign release_pulse[i] = rel;
      assign repeat_pulse[i] = rpt;
   end
endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised N-channel successor to the 2-button scanner used on the Nexys A7 top level.
- Per channel: two-flop synchronisation, polarity normalisation, tick-based debounce, and a clean level output with one-cycle press/release pulses.
- Optional per-channel auto-repeat (long-press) for stepping the pipeline core in debug mode.
- Sits between the raw board buttons and the core's debug_step/interrupt inputs, clocked by the display clock.

Parameters:
N, 2, number of button channels
TICK_CYCLES, 25000, clk cycles per timebase tick (1 ms at 25 MHz); the bench overrides it small
DEBOUNCE_TICKS, 10, ticks the input must stay stable before a press or release is accepted (>=1)
REPEAT_DELAY_TICKS, 500, hold time from accepted press to first repeat pulse (>=1)
REPEAT_RATE_TICKS, 100, interval between later repeat pulses (>=1)
ACTIVE_HIGH, 1, 1 = pressed reads 1; 0 = pressed reads 0

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
btn_in  in  N  raw, asynchronous button inputs
repeat_en  in  N  per-channel auto-repeat enable
level  out  N  debounced pressed state (1 = pressed)
press  out  N  one-cycle pulse on accepted press and on each repeat
release  out  N  one-cycle pulse on accepted release
repeat  out  N  one-cycle pulse, asserted together with press only for repeat events

Behaviour:
- Reset (rstn=0, async):
  - Synchroniser flops load the inactive level: 0 if ACTIVE_HIGH, 1 otherwise.
  - Prescaler = 0, all channel FSMs = IDLE, all counters = 0.
  - level, press, release and repeat all = 0.
  - Reset asserted mid-operation aborts all activity without emitting any pulse.
- Synchroniser: 2 flops per bit. s = synchronised value XOR ~ACTIVE_HIGH, so s=1 means pressed. Sync latency is 2 cycles.
- Prescaler:
  - One shared counter, 0..TICK_CYCLES-1.
  - tick=1 for the one cycle in which the counter equals TICK_CYCLES-1; the counter then wraps to 0.
  - The prescaler free-runs and is never reset by channel events.
- Per-channel FSM, each with its own counter cnt. Width = clog2(max tick parameter), saturating is not needed.
  - IDLE: if s=1, go to DB_PRESS with cnt=0.
  - DB_PRESS:
    - s=0: go to IDLE (bounce rejected, no pulse).
    - tick with cnt=DEBOUNCE_TICKS-1: go to HELD, cnt=0, level<=1, press<=1.
    - Other ticks: cnt+1.
  - HELD:
    - s=0: go to DB_REL, cnt=0.
    - repeat_en=0: cnt held at 0.
    - repeat_en=1, tick with cnt=REPEAT_DELAY_TICKS-1: go to REPEAT, cnt=0, press<=1, repeat<=1.
    - Other ticks with repeat_en=1: cnt+1.
  - REPEAT:
    - s=0: go to DB_REL, cnt=0.
    - repeat_en=0: go to HELD, cnt=0.
    - tick with cnt=REPEAT_RATE_TICKS-1: cnt=0, press<=1, repeat<=1.
    - Other ticks: cnt+1.
  - DB_REL:
    - s=1: go to HELD, cnt=0 (release rejected; the repeat sequence restarts from the full delay).
    - tick with cnt=DEBOUNCE_TICKS-1: go to IDLE, level<=0, release<=1.
    - Other ticks: cnt+1.
- Priority: a change in s outranks a tick in the same cycle (state changes, no count, no pulse).
- Outputs:
  - All outputs are registered.
  - Pulses are exactly one cycle wide.
  - press and release are never asserted together on one channel.
  - Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Latency: from an input edge to the pulse is 2 (sync) + 1 (state entry) + between (DEBOUNCE_TICKS-1)*TICK_CYCLES+1 and DEBOUNCE_TICKS*TICK_CYCLES + 1 (output register) cycles.

Test Plan:
Bench parameters for all scenarios: TICK_CYCLES=4, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2, N=2.
1. Clean press on ch0 held 100 cycles, then released -> exactly one press pulse 12-16 cycles after the rising edge; level=1 until one release pulse 12-16 cycles after the falling edge; ch1 silent.
2. Bounce: ch0 toggles every 3 cycles for 30 cycles, then settles high -> no pulse during the bouncing; exactly one press within 16 cycles after settling.
3. Repeat: ch0 held with repeat_en=1 -> initial press (repeat=0), then press+repeat 20 cycles later, then every 8 cycles; dropping repeat_en stops the repeats with no further pulses.
4. Release glitch: while HELD, ch0 drops for 5 cycles (less than 3 ticks) -> no release; level stays 1.
5. Simultaneous: ch0 and ch1 pressed in the same cycle -> press[1:0]=2'b11 in a single cycle.
6. Reset mid-debounce: pull rstn low while in DB_PRESS -> all outputs 0 immediately; after release of rstn with the button still held, one fresh press only after a full debounce.
